// File: rtl/seg7_scan_controller.sv
// Four-digit multiplexed 7-segment driver: loads a 14-bit binary value, converts it to BCD one bit per
// cycle (double dabble), and scans the digits with a blanked dead-time at the start of each slot.
module seg7_scan_controller #(
   parameter int SCAN_DIV     = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int LZ_BLANK     = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] value,
   input  logic        load,
   input  logic        blank,
   output logic        busy,
   output logic        overflow,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

   typedef enum logic {IDLE, CONV} state_t;

   state_t        state_q, state_d;
   logic [13:0]   bin_q, bin_d;
   logic [15:0]   bcd_q, bcd_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          ovf_pend_q, ovf_pend_d;
   logic [15:0]   disp_q, disp_d;
   logic          ovf_q, ovf_d;
   logic          busy_q, busy_d;
   logic [CW-1:0] slot_q, slot_d;
   logic [1:0]    dig_q, dig_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   logic [15:0]   bcd_adj;
   logic [29:0]   shift_w;
   logic [3:0]    upper_zero;
   logic [3:0]    nib;
   logic          suppress, active;

   // Add-3 correction on every nibble before the shift.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                                : bcd_q[gi*4 +: 4];
      end
      for (genvar gi = 1; gi < 4; gi++) begin : g_uz
         assign upper_zero[gi] = (disp_q[15:gi*4] == '0);
      end
   endgenerate
   assign upper_zero[0] = 1'b0;

   // Bits leaving bcd[15] belong to a ten-thousands digit, so any of them means the value exceeds 9999.
   assign shift_w = {bcd_adj[14:0], bin_q, 1'b0};

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      disp_d     = disp_q;
      ovf_d      = ovf_q;
      busy_d     = busy_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               bin_d      = value;
               bcd_d      = '0;
               cnt_d      = 4'd14;
               ovf_pend_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = CONV;
            end
         end
         CONV: begin
            bin_d      = shift_w[13:0];
            bcd_d      = shift_w[29:14];
            cnt_d      = cnt_q - 4'd1;
            ovf_pend_d = ovf_pend_q | bcd_adj[15];
            if (cnt_q == 4'd1) begin
               disp_d  = shift_w[29:14];
               ovf_d   = ovf_pend_q | bcd_adj[15];
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      dig_d  = (slot_q == SLOT_LAST) ? dig_q + 2'd1 : dig_q;
      case (dig_q)
         2'd0:    nib = disp_q[3:0];
         2'd1:    nib = disp_q[7:4];
         2'd2:    nib = disp_q[11:8];
         default: nib = disp_q[15:12];
      endcase
      suppress = (LZ_BLANK != 0) && !ovf_q && upper_zero[dig_q];
      active   = !blank && (slot_q >= BLANK_END) && !suppress;
      an_d     = 4'hF;
      seg_d    = 7'h7F;
      if (active) begin
         an_d = ~(4'b0001 << dig_q);
         if (ovf_q) begin
            seg_d = 7'h3F;
         end else begin
            case (nib)
               4'd0:    seg_d = 7'h40;
               4'd1:    seg_d = 7'h79;
               4'd2:    seg_d = 7'h24;
               4'd3:    seg_d = 7'h30;
               4'd4:    seg_d = 7'h19;
               4'd5:    seg_d = 7'h12;
               4'd6:    seg_d = 7'h02;
               4'd7:    seg_d = 7'h78;
               4'd8:    seg_d = 7'h00;
               4'd9:    seg_d = 7'h10;
               default: seg_d = 7'h7F;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         disp_q     <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         slot_q     <= '0;
         dig_q      <= '0;
         an_q       <= 4'hF;
         seg_q      <= 7'h7F;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         disp_q     <= disp_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
         slot_q     <= slot_d;
         dig_q      <= dig_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign busy     = busy_q;
   assign overflow = ovf_q;
   assign seg      = seg_q;
   assign an       = an_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller: expected displays queued at each load, popped when busy falls,
// and the scan outputs compared every cycle against a timing model of the slot schedule.
module tb_seg7_scan_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [13:0] value = '0;
   logic        load = 1'b0;
   logic        blank = 1'b0;
   logic        busy, overflow;
   logic [6:0]  seg;
   logic [3:0]  an;

   typedef struct packed {
      logic        ovf;
      logic [3:0]  show;
      logic [27:0] segs;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   errors = 0;
   int   checks = 0;
   int   edge_n = 0;
   logic blk_q = 1'b0;

   seg7_scan_controller #(.SCAN_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1)) dut (
      .clk(clk), .reset(reset), .value(value), .load(load), .blank(blank),
      .busy(busy), .overflow(overflow), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   // Edge count since reset release and the blank level each edge saw.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_n <= 0;
         blk_q  <= 1'b0;
      end else begin
         edge_n <= edge_n + 1;
         blk_q  <= blank;
      end
   end

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  default: return 7'h10;
      endcase
   endfunction

   function automatic exp_t mk(input int v);
      exp_t e;
      if (v > 9999) begin
         e.ovf  = 1'b1;
         e.show = 4'hF;
         e.segs = {4{7'h3F}};
      end else begin
         e.ovf  = 1'b0;
         e.show = {v >= 1000, v >= 100, v >= 10, 1'b1};
         e.segs = {seg_of(v / 1000), seg_of((v / 100) % 10), seg_of((v / 10) % 10), seg_of(v % 10)};
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic check_scan();
      logic [3:0] e_an;
      logic [6:0] e_seg;
      int c, d;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      if (!reset && edge_n > 0) begin
         c = (edge_n - 1) % 8;
         d = ((edge_n - 1) / 8) % 4;
         if (!blk_q && c >= 2 && cur.show[d]) begin
            e_an  = ~(4'b0001 << d);
            e_seg = cur.segs[d*7 +: 7];
         end
      end
      chk("an", {28'd0, an}, {28'd0, e_an});
      chk("seg", {25'd0, seg}, {25'd0, e_seg});
   endtask

   task automatic step();
      @(negedge clk);
      check_scan();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic start_load(input int v);
      value = 14'(v);
      load  = 1'b1;
      q.push_back(mk(v));
      $display("load value=%0d at edge %0d", v, edge_n + 1);
      step();
      load = 1'b0;
      chk("busy_after_load", {31'd0, busy}, 32'd1);
   endtask

   // Waits for busy to fall; with hammer set, load 9999 is held high from three cycles in.
   task automatic finish_conv(input bit hammer);
      int cnt;
      cnt = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (busy !== 1'b1) break;
         cnt++;
         if (hammer && cnt >= 3) begin
            value = 14'd9999;
            load  = 1'b1;
         end
      end
      load = 1'b0;
      chk("busy_cycles", cnt, 14);
      cur = q.pop_front();
      chk("overflow", {31'd0, overflow}, {31'd0, cur.ovf});
      $display("conversion done: busy cycles=%0d overflow=%0b", cnt, overflow);
   endtask

   initial begin
      cur = mk(0);
      #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_busy", {31'd0, busy}, 32'd0);
         chk("reset_ovf", {31'd0, overflow}, 32'd0);
      end
      reset = 1'b0;
      steps(32);

      start_load(1234);
      finish_conv(1'b0);
      steps(33);

      start_load(10000);
      finish_conv(1'b0);
      steps(33);

      start_load(507);
      finish_conv(1'b0);
      steps(33);

      start_load(42);
      finish_conv(1'b1);
      start_load(9999);
      finish_conv(1'b0);
      steps(33);

      blank = 1'b1;
      $display("blank asserted at edge %0d", edge_n + 1);
      steps(64);
      blank = 1'b0;
      steps(33);

      start_load(10000);
      finish_conv(1'b0);
      steps(4);
      start_load(1234);
      steps(6);
      reset = 1'b1;
      #1;
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      chk("midreset_ovf", {31'd0, overflow}, 32'd0);
      chk("midreset_an", {28'd0, an}, 32'hF);
      void'(q.pop_front());
      cur = mk(0);
      $display("reset asserted mid-conversion");
      steps(2);
      reset = 1'b0;
      steps(32);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Display scheduler for the reaction-time tester's 4-digit multiplexed 7-segment display.
- Accepts a binary millisecond result with a load strobe and converts it to BCD with an iterative, one-bit-per-cycle double-dabble sequencer.
- Time-shares the single segment bus among the four digits with a rotating scan and a dead-time interval between digits to prevent ghosting.
- Sits between the reaction-time FSM and the seg/an pins.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot. Must be ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Must be < SCAN_DIV.
- LZ_BLANK, 1: 1 = suppress leading zeros on digits 3..1; 0 = show all digits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- value  in  14  binary value to display (0..16383)
- load  in  1  one-cycle strobe; capture value and start conversion
- blank  in  1  1 = all anodes off; scan timing keeps running
- busy  out  1  conversion in progress; load is ignored while high
- overflow  out  1  last committed value was > 9999
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g
- an  out  4  digit anodes, active-low; an[0]=ones … an[3]=thousands

Behaviour:
- All outputs are registered.
- Reset (asynchronous, active-high):
  - an=4'b1111, seg=7'h7F, busy=0, overflow=0.
  - Display BCD register cleared to 0000.
  - Scan slot counter and digit index set to 0.
  - Any conversion in progress is aborted.
- Conversion FSM, states IDLE and CONV:
  - IDLE: load=1 at edge E0 captures value, clears the BCD shift register, sets the shift count to 14, and enters CONV. busy=1 after E0.
  - CONV: at edges E1..E14, each BCD nibble ≥ 5 gets +3, then {bcd, bin} shifts left by 1.
  - At E14 the result commits to the display register. overflow = (captured value > 9999). busy=0 and the FSM returns to IDLE.
  - busy is high for exactly 14 cycles.
  - load during CONV is ignored; there is no queueing.
  - load in the cycle busy falls (E14) is ignored. The next load is accepted at E15 or later.
  - Overflow case: the conversion still runs the full 14 cycles. The committed display shows "----" (7'h3F on all four digits), and leading-zero blanking is not applied.
- Scan scheduler:
  - Slot counter runs 0..SCAN_DIV-1 and then wraps. On wrap, the digit index advances 0→1→2→3→0.
  - Counter values 0..BLANK_CYCLES-1: an=4'b1111 and seg=7'h7F.
  - Remaining counter values: an has only the bit for the current digit low, and seg shows that digit's pattern.
  - Digit k (k ≥ 1) is suppressed (anode stays high, seg=7'h7F for the slot) when LZ_BLANK=1, overflow=0, and digits k..3 are all 0. Digit 0 is always shown.
  - blank=1 forces an=4'b1111 and seg=7'h7F. Counter and index continue unaffected.
  - A commit in mid-slot updates seg on the next cycle. The slot timing is not restarted.
- Segment encoding (active-low, hex values of seg[6:0]):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, dash=3F, off=7F.
- Output latency: an and seg reflect the counter and index state registered one cycle earlier. The timing is fixed and identical for every slot.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1):
- Reset held 3 cycles, then released:
  - During reset: an=1111, seg=7F.
  - Slot 0: cycles 0–1 an=1111; cycles 2–7 an=1110, seg=40.
  - Slots 1–3: an=1111 throughout.
- load with value=1234:
  - busy=1 for exactly 14 cycles.
  - Slots then show: an=1110/seg=19, an=1101/seg=30, an=1011/seg=24, an=0111/seg=79.
- load with value=10000:
  - After 14 cycles overflow=1.
  - All four slots show seg=3F, each with its anode active.
- load with value=507:
  - Thousands slot has an=1111.
  - Hundreds seg=12, tens seg=40 (not blanked), ones seg=78.
- Busy and blank handling:
  - load 42, then load 9999 three cycles later: display shows 42 (tens 19, ones 24) and the second load is ignored.
  - load 9999 again at E15: accepted.
  - blank=1 for 2 full scan rotations: an=1111 throughout; slot timing unchanged when blank is released.
- Reset mid-conversion:
  - load 1234, assert reset at cycle 7: busy=0 immediately and overflow=0.
  - After release, only digit 0 shows seg=40.
